usb_rx_line_recovery: RTL and testbench
=======================================

// Module: usb_rx_line_recovery
// PURPOSE
//  Full-speed USB receive front end, directly downstream of the pad input conditioning stage.
//  Resynchronises the conditioned D+/D- levels and decodes the line state.
//  Recovers bit timing with an oversampling DPLL, then NRZI-decodes and removes stuffed bits.
//  Delivers a bit stream with a valid strobe, plus EOP and stuff-error pulses, to the packet decoder.
// PARAMETERS
//  OVERSAMPLE   4  clk cycles per USB bit; power of two, >=4
//  STUFF_LIMIT  6  consecutive decoded 1s after which a stuffed 0 is expected
// PORTS
//  clk         in   1  system clock (OVERSAMPLE x bit rate)
//  rst_n       in   1  asynchronous active-low reset
//  dp_i        in   1  conditioned D+ level
//  dm_i        in   1  conditioned D- level
//  rx_en       in   1  receiver enable; 0 forces IDLE
//  line_state  out  2  {dp,dm} after sync/filter: 10=J, 01=K, 00=SE0, 11=SE1
//  rx_active   out  1  high from first K after idle until EOP or error
//  rx_bit      out  1  decoded (NRZI-decoded, unstuffed) data bit
//  rx_valid    out  1  1-cycle strobe qualifying rx_bit
//  eop         out  1  1-cycle pulse on valid end-of-packet
//  stuff_err   out  1  1-cycle pulse on stuffing violation or illegal EOP
// BEHAVIOUR
//  - Reset: all flops 0; line_state=00, rx_active=0, rx_bit=0, rx_valid=0, eop=0, stuff_err=0, FSM=IDLE.
//  - Sync: 2-flop synchroniser per line. dp_i/dm_i reach line_state after 2 clk edges.
//  - DPLL phase counter, log2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1.
//  - On any J<->K change of the filtered line, phase is cleared to 0.
//  - A sample point occurs when phase == OVERSAMPLE/2, i.e. 2 clks after an edge at default.
//  - SE0/SE1 transitions do not realign phase.
//  - FSM IDLE: rx_active=0. A J->K change enters ACTIVE.
//    - Entry sets prev_level=J, ones_cnt=0, rx_active=1 on the same cycle.
//  - FSM ACTIVE, at each sample point:
//    - J/K sample: raw = (sample==prev_level); prev_level <= sample.
//    - raw=1: if ones_cnt==STUFF_LIMIT -> stuff_err pulse, go to ERR. Else emit bit, ones_cnt++.
//    - raw=0: if ones_cnt==STUFF_LIMIT, bit is dropped (no rx_valid). Else emit 0. Either way ones_cnt=0.
//    - Emit means rx_bit/rx_valid are registered 1 clk after the sample point.
//    - SE0 sample -> EOP state, no emit.
//    - SE1 sample -> stuff_err, go to ERR.
//  - FSM EOP, at each sample point:
//    - SE0: stay; after 3 SE0 samples total -> stuff_err, go to ERR.
//    - J: eop pulse, rx_active=0 next cycle, go to IDLE.
//    - K or SE1: stuff_err, go to ERR.
//  - FSM ERR: rx_active=0; return to IDLE after J is sampled at 2 consecutive sample points.
//  - rx_en=0, or reset asserted at any time including mid-packet:
//    - FSM -> IDLE, rx_active/rx_valid/eop/stuff_err = 0 next cycle (reset: immediately).
//    - Any partial bit is discarded. Synchroniser and line_state continue while rx_en=0.
//  - eop and stuff_err are never asserted in the same cycle; rx_valid is never high with eop.
// CONFIGURATION
//  - USB_RX_GLITCH_FILTER_EN defined: after the synchroniser, {dp,dm} must be identical for
//    2 consecutive clks before the filtered state updates.
//    - Single-cycle glitches are rejected.
//    - dp_i-to-line_state latency is 3 clks; DPLL and FSM use the filtered value.
//  - Undefined: filtered state = synchronised value; latency 2 clks; no glitch rejection.
// TESTING (OVERSAMPLE=4, STUFF_LIMIT=6)
//  - SYNC: J idle, then K,J,K,J,K,J,K,K at 4 clks/bit, then SE0,SE0,J.
//    -> rx_active rises 2 clks after first K.
//    -> 8 strobes with bits 0,0,0,0,0,0,0,1, then eop pulse, rx_active falls.
//  - Stuffing: after SYNC, 6 decoded 1s then a transition (stuffed 0), then a 0.
//    -> 7 rx_valid strobes (six 1s, one 0); stuffed bit not strobed; no stuff_err.
//  - Violation: after SYNC, 7 consecutive 1s.
//    -> stuff_err pulse on 7th sample, rx_active=0.
//    -> No further rx_valid until 2 J samples, then IDLE.
//  - Drift: bits of 5 clks then 3 clks alternating, 32 bits.
//    -> all 32 decoded bits correct, none duplicated or lost.
//  - Abort: rst_n low for 1 clk mid-payload.
//    -> all outputs 0 immediately; FSM IDLE.
//    -> Next SYNC decodes normally; same result with rx_en=0 for 1 clk.
//  - Glitch, with USB_RX_GLITCH_FILTER_EN: 1-clk K pulse on idle J.
//    -> rx_active stays 0, line_state stays 10.
//  - Glitch, without the macro: same pulse -> rx_active rises.

Source files
------------

// File: rtl/usb_rx_line_recovery.sv
// Full-speed USB receive front end: sync, line decode, DPLL, NRZI decode, unstuff.
// Optional USB_RX_GLITCH_FILTER_EN adds a 2-clk agreement filter after the synchroniser.
module usb_rx_line_recovery #(
    parameter int OVERSAMPLE  = 4,
    parameter int STUFF_LIMIT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp_i,
    input  logic       dm_i,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_bit,
    output logic       rx_valid,
    output logic       eop,
    output logic       stuff_err
);

    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int CW = $clog2(STUFF_LIMIT + 1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [PW-1:0] SAMPLE_PH = PW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] ONES_MAX  = CW'(STUFF_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_EOP,
        S_ERR
    } state_t;

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {dp_i, dm_i};
            sync2_q <= sync1_q;
        end
    end

`ifdef USB_RX_GLITCH_FILTER_EN
    logic [1:0] filt_q;

    // Accept a new level only once two successive synchronised samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 2'b00;
        end else if (sync1_q == sync2_q) begin
            filt_q <= sync2_q;
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    assign line_state = line;

    logic [1:0]    last_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_cur;
    logic          now_jk;
    logic          last_jk;
    logic          jk_edge;
    logic          sample_pt;

    assign now_jk    = (line == LS_J) || (line == LS_K);
    assign last_jk   = (last_q == LS_J) || (last_q == LS_K);
    assign jk_edge   = now_jk && last_jk && (line != last_q);
    // The edge cycle itself is phase 0, so the sample lands mid-bit.
    assign phase_cur = jk_edge ? '0 : phase_q;
    assign sample_pt = (phase_cur == SAMPLE_PH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 2'b00;
            phase_q <= '0;
        end else begin
            last_q  <= line;
            phase_q <= phase_cur + 1'b1;
        end
    end

    state_t        state_q;
    logic [1:0]    prev_q;
    logic [CW-1:0] ones_q;
    logic [1:0]    se0_q;
    logic          jcnt_q;
    logic          active_q;
    logic          bit_q;
    logic          valid_q;
    logic          eop_q;
    logic          serr_q;
    logic          start;

    assign start = rx_en && (state_q == S_IDLE) && jk_edge && (line == LS_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prev_q   <= 2'b00;
            ones_q   <= '0;
            se0_q    <= 2'b00;
            jcnt_q   <= 1'b0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            eop_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            serr_q  <= 1'b0;
            if (!rx_en) begin
                state_q  <= S_IDLE;
                active_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q  <= S_ACTIVE;
                            prev_q   <= LS_J;
                            ones_q   <= '0;
                            active_q <= 1'b1;
                        end
                    end
                    S_ACTIVE: begin
                        if (sample_pt) begin
                            unique case (line)
                                LS_J, LS_K: begin
                                    prev_q <= line;
                                    if (line == prev_q) begin
                                        if (ones_q == ONES_MAX) begin
                                            serr_q   <= 1'b1;
                                            active_q <= 1'b0;
                                            jcnt_q   <= 1'b0;
                                            state_q  <= S_ERR;
                                        end else begin
                                            bit_q   <= 1'b1;
                                            valid_q <= 1'b1;
                                            ones_q  <= ones_q + 1'b1;
                                        end
                                    end else begin
                                        // After a full run of ones this 0 is the stuffed bit.
                                        if (ones_q != ONES_MAX) begin
                                            bit_q   <= 1'b0;
                                            valid_q <= 1'b1;
                                        end
                                        ones_q <= '0;
                                    end
                                end
                                LS_SE0: begin
                                    se0_q   <= 2'd1;
                                    state_q <= S_EOP;
                                end
                                LS_SE1: begin
                                    serr_q   <= 1'b1;
                                    active_q <= 1'b0;
                                    jcnt_q   <= 1'b0;
                                    state_q  <= S_ERR;
                                end
                            endcase
                        end
                    end
                    S_EOP: begin
                        if (sample_pt) begin
                            if (line == LS_SE0) begin
                                if (se0_q == 2'd2) begin
                                    serr_q   <= 1'b1;
                                    active_q <= 1'b0;
                                    jcnt_q   <= 1'b0;
                                    state_q  <= S_ERR;
                                end else begin
                                    se0_q <= se0_q + 2'd1;
                                end
                            end else if (line == LS_J) begin
                                eop_q    <= 1'b1;
                                active_q <= 1'b0;
                                state_q  <= S_IDLE;
                            end else begin
                                serr_q   <= 1'b1;
                                active_q <= 1'b0;
                                jcnt_q   <= 1'b0;
                                state_q  <= S_ERR;
                            end
                        end
                    end
                    S_ERR: begin
                        if (sample_pt) begin
                            if (line == LS_J) begin
                                jcnt_q <= 1'b1;
                                if (jcnt_q) begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                jcnt_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rx_active = active_q | start;
    assign rx_bit    = bit_q;
    assign rx_valid  = valid_q;
    assign eop       = eop_q;
    assign stuff_err = serr_q;

endmodule

// File: tb/tb_usb_rx_line_recovery.sv
// Directed bench for usb_rx_line_recovery (OVERSAMPLE=4, STUFF_LIMIT=6).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_usb_rx_line_recovery;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dp_i;
    logic       dm_i;
    logic       rx_en;
    logic [1:0] line_state;
    logic       rx_active;
    logic       rx_bit;
    logic       rx_valid;
    logic       eop;
    logic       stuff_err;

    always #5 clk = ~clk;

    usb_rx_line_recovery #(
        .OVERSAMPLE (4),
        .STUFF_LIMIT(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dp_i      (dp_i),
        .dm_i      (dm_i),
        .rx_en     (rx_en),
        .line_state(line_state),
        .rx_active (rx_active),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .eop       (eop),
        .stuff_err (stuff_err)
    );

`ifdef USB_RX_GLITCH_FILTER_EN
    localparam int   LAT  = 3;
    localparam logic FILT = 1'b1;
`else
    localparam int   LAT  = 2;
    localparam logic FILT = 1'b0;
`endif

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   eop_cnt  = 0;
    int   se_cnt   = 0;
    int   bad_cnt  = 0;
    logic act_seen = 1'b0;
    logic ls_dev   = 1'b0;
    logic q_bits[$];
    logic [1:0]  cur;
    logic [31:0] dd;

    always @(negedge clk) begin
        if (rx_valid) q_bits.push_back(rx_bit);
        if (eop) eop_cnt++;
        if (stuff_err) se_cnt++;
        if ((eop && stuff_err) || (eop && rx_valid)) bad_cnt++;
        if (rx_active) act_seen = 1'b1;
        if (line_state != J) ls_dev = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] lv, input int n);
        {dp_i, dm_i} = lv;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        if (!b) cur = ~cur;
        drive(cur, n);
    endtask

    task automatic do_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0, 4);
        send_bit(1'b1, 4);
    endtask

    task automatic do_eop();
        drive(SE0, 8);
        cur = J;
        drive(cur, 12);
    endtask

    task automatic clear();
        q_bits.delete();
        eop_cnt = 0;
        se_cnt  = 0;
    endtask

    function automatic logic [63:0] bits_val();
        logic [63:0] v = '0;
        for (int i = 0; i < q_bits.size() && i < 64; i++) v[i] = q_bits[i];
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        rx_en = 1'b1;
        cur   = J;
        {dp_i, dm_i} = J;
        repeat (3) @(negedge clk);
        check("reset_line", line_state, 2'b00);
        check("reset_outs", {rx_active, rx_bit, rx_valid, eop, stuff_err}, 0);
        rst_n = 1'b1;
        drive(J, 8);
        check("idle_line", line_state, J);
        check("idle_active", rx_active, 0);

        // SYNC with rx_active rise timing
        clear();
        cur = K;
        drive(cur, LAT - 1);
        check("act_before", rx_active, 0);
        drive(cur, 1);
        check("act_rise", rx_active, 1);
        check("line_k", line_state, K);
        drive(cur, 4 - LAT);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        do_eop();
        check("sync_count", q_bits.size(), 8);
        check("sync_bits", bits_val(), 64'h80);
        check("sync_eop", eop_cnt, 1);
        check("sync_serr", se_cnt, 0);
        check("sync_act_end", rx_active, 0);

        // Stuffed zero after six ones
        clear();
        do_sync();
        repeat (5) send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        send_bit(1'b0, 4);
        do_eop();
        check("stuff_count", q_bits.size(), 14);
        check("stuff_bits", bits_val(), 64'h1F80);
        check("stuff_serr", se_cnt, 0);
        check("stuff_eop", eop_cnt, 1);

        // Seven ones: stuffing violation, then recovery
        clear();
        do_sync();
        repeat (6) send_bit(1'b1, 4);
        drive(cur, 2);
        check("viol_serr", se_cnt, 1);
        check("viol_act", rx_active, 0);
        check("viol_count", q_bits.size(), 13);
        check("viol_bits", bits_val(), 64'h1F80);
        drive(cur, 8);
        cur = J;
        drive(cur, 12);
        check("viol_hold_count", q_bits.size(), 13);
        check("viol_eop", eop_cnt, 0);
        clear();
        do_sync();
        do_eop();
        check("viol_rec_count", q_bits.size(), 8);
        check("viol_rec_eop", eop_cnt, 1);

        // Drift: 5/3 clk bits
        clear();
        dd = 32'hA5C3_3C5A;
        do_sync();
        for (int i = 0; i < 32; i++) send_bit(dd[i], (i % 2 == 0) ? 5 : 3);
        do_eop();
        check("drift_count", q_bits.size(), 40);
        check("drift_bits", bits_val(), {24'h0, 32'hA5C3_3C5A, 8'h80});
        check("drift_eop", eop_cnt, 1);
        check("drift_serr", se_cnt, 0);

        // Reset mid-payload
        clear();
        do_sync();
        send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        rst_n = 1'b0;
        #1;
        check("rst_outs", {line_state, rx_active, rx_bit, rx_valid, eop, stuff_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur = J;
        drive(cur, 10);
        check("rst_eop", eop_cnt, 0);
        check("rst_serr", se_cnt, 0);
        clear();
        do_sync();
        do_eop();
        check("rst_rec_count", q_bits.size(), 8);
        check("rst_rec_bits", bits_val(), 64'h80);
        check("rst_rec_eop", eop_cnt, 1);

        // rx_en low mid-payload
        clear();
        do_sync();
        send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        rx_en = 1'b0;
        @(negedge clk);
        check("en_outs", {rx_active, rx_valid, eop, stuff_err}, 0);
        rx_en = 1'b1;
        cur = J;
        drive(cur, 10);
        check("en_eop", eop_cnt, 0);
        check("en_serr", se_cnt, 0);
        clear();
        do_sync();
        do_eop();
        check("en_rec_count", q_bits.size(), 8);
        check("en_rec_bits", bits_val(), 64'h80);
        check("en_rec_eop", eop_cnt, 1);

        // Single-clock K glitch on idle
        cur = J;
        drive(J, 8);
        act_seen = 1'b0;
        ls_dev   = 1'b0;
        drive(K, 1);
        drive(J, 60);
        check("glitch_act", act_seen, !FILT);
        check("glitch_line", ls_dev, !FILT);
        check("glitch_end_act", rx_active, 0);

        check("no_overlap", bad_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
